// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//   Pipelined add/subtract unit. Operands are cut into SLICE-bit slices and one
//   slice is resolved per pipeline stage, so the critical path is a single
//   SLICE-bit ripple regardless of WIDTH. The carry is registered between
//   stages; the not-yet-used operand slices ride along in skew registers and
//   the already-resolved result slices accumulate until they land, aligned,
//   in the last stage, which doubles as the output register.
//
//   Latency is STAGES = WIDTH/SLICE cycles, throughput one op per cycle.
//
// Parameters
//   WIDTH  operand/result width (WIDTH % SLICE == 0, WIDTH >= SLICE)
//   SLICE  bits resolved per stage
//
// Ports
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   In_valid   in   A/B/Cin/Sub carry an operation
//   In_ready   out  unit accepts an operation this cycle
//   A, B       in   operands
//   Cin        in   carry-in for add (ignored for subtract)
//   Sub        in   1: A - B, 0: A + B + Cin
//   Out_valid  out  Sum/Cout/Ovf hold a result
//   Out_ready  in   consumer takes the result this cycle
//   Sum        out  result (wrapped, or saturated on overflow)
//   Cout       out  carry out of the MSB (for subtract: 1 = no borrow)
//   Ovf        out  signed two's-complement overflow
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. In_ready is combinational: the whole pipe advances when the output
//   register is empty or being drained, otherwise every stage holds.
//
// Configuration
//   ADDER_PIPE_SAT_EN  when defined, Sum saturates on signed overflow
//                      (0111..1 for positive, 1000..0 for negative overflow).
//                      Cout and Ovf always report the raw result.
// -----------------------------------------------------------------------------
module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / SLICE;

    // Global advance: the pipe moves only when the last stage can be vacated.
    logic adv;

    // Per-stage registers. a/b hold the full (pre-inverted) operands so the
    // upcoming slices and the sign bits travel with the op; sum accumulates
    // the resolved slices.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;

    // What each stage sees at its input: stage 0 from the ports, stage k from
    // the registers of stage k-1.
    logic [WIDTH-1:0]  in_a [STAGES];
    logic [WIDTH-1:0]  in_b [STAGES];
    logic [WIDTH-1:0]  in_s [STAGES];
    logic [STAGES-1:0] in_c;
    logic [STAGES-1:0] in_v;

    logic [SLICE:0]    slice_res [STAGES];
    logic [WIDTH-1:0]  raw_sum;
    logic [WIDTH-1:0]  final_sum;

    assign adv = !valid_q[STAGES-1] || Out_ready;

    // -------------------------------------------------------------------------
    // Stage input selection
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            in_a[k] = '0;
            in_b[k] = '0;
            in_s[k] = '0;
        end
        in_c = '0;
        in_v = '0;

        // Subtract is A + ~B + 1: invert B up front and force the carry-in.
        in_a[0] = A;
        in_b[0] = Sub ? ~B : B;
        in_s[0] = '0;
        in_c[0] = Sub ? 1'b1 : Cin;
        in_v[0] = In_valid;

        for (int k = 1; k < STAGES; k++) begin
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_s[k] = sum_q[k-1];
            in_c[k] = carry_q[k-1];
            in_v[k] = valid_q[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // Slice adders and final-stage overflow / saturation
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_res[k] = '0;
            sum_d[k]     = '0;
            a_d[k]       = '0;
            b_d[k]       = '0;
        end
        carry_d   = '0;
        valid_d   = '0;
        raw_sum   = '0;
        final_sum = '0;
        ovf_d     = 1'b0;

        for (int k = 0; k < STAGES; k++) begin
            slice_res[k] = {1'b0, in_a[k][k*SLICE +: SLICE]}
                         + {1'b0, in_b[k][k*SLICE +: SLICE]}
                         + {{SLICE{1'b0}}, in_c[k]};
            sum_d[k]                  = in_s[k];
            sum_d[k][k*SLICE +: SLICE] = slice_res[k][SLICE-1:0];
            carry_d[k]                = slice_res[k][SLICE];
            a_d[k]                    = in_a[k];
            b_d[k]                    = in_b[k];
            valid_d[k]                = in_v[k];
        end

        // Overflow needs the operand sign bits, which reached the last stage
        // through the skew registers, and the full raw sum.
        raw_sum = sum_d[STAGES-1];
        ovf_d   = (in_a[STAGES-1][WIDTH-1] == in_b[STAGES-1][WIDTH-1]) &&
                  (raw_sum[WIDTH-1] != in_a[STAGES-1][WIDTH-1]);

        final_sum = raw_sum;
`ifdef ADDER_PIPE_SAT_EN
        // Both operands share a sign when overflow occurs; that sign picks
        // the direction of the clamp.
        if (ovf_d) begin
            if (in_a[STAGES-1][WIDTH-1]) begin
                final_sum = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                final_sum = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
`endif
        sum_d[STAGES-1] = final_sum;
    end

    // -------------------------------------------------------------------------
    // Pipeline registers: all stages load together or all hold.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign In_ready  = adv;
    assign Out_valid = valid_q[STAGES-1];
    assign Sum       = sum_q[STAGES-1];
    assign Cout      = carry_q[STAGES-1];
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//   Bench for adder_pipe. Main instance: WIDTH=32, SLICE=8 (four stages).
//   Second instance: WIDTH=16, SLICE=16 (single registered adder).
//   Expected results come from a signed/unsigned arithmetic model pushed into
//   an expected queue at accept time and popped at every output transfer.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

  localparam int W      = 32;
  localparam int STAGES = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  adder_pipe #(.WIDTH(32), .SLICE(8)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .In_valid(in_valid), .In_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .Out_valid(out_valid), .Out_ready(out_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  // ---------------- single-stage DUT ----------------
  logic        s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
  logic [15:0] s_a, s_b, s_sum;

  adder_pipe #(.WIDTH(16), .SLICE(16)) dut_s (
    .Clk(clk), .Rst_n(rst_n),
    .In_valid(s_in_valid), .In_ready(s_in_ready),
    .A(s_a), .B(s_b), .Cin(s_cin), .Sub(s_sub),
    .Out_valid(s_out_valid), .Out_ready(s_out_ready),
    .Sum(s_sum), .Cout(s_cout), .Ovf(s_ovf)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;
  logic        hold_pending = 1'b0;
  logic [33:0] held_vals;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {sum, cout, ovf} from plain signed/unsigned arithmetic.
  function automatic logic [33:0] model(input logic [31:0] op_a, input logic [31:0] op_b,
                                        input logic c_in, input logic is_sub);
    longint      sa, sb, s;
    logic [32:0] u;
    logic [31:0] r;
    logic        co, ov;
    sa = longint'($signed(op_a));
    sb = longint'($signed(op_b));
    if (is_sub) begin
      s  = sa - sb;
      co = (op_a >= op_b);
    end else begin
      s  = sa + sb + longint'(c_in);
      u  = {1'b0, op_a} + {1'b0, op_b} + {32'd0, c_in};
      co = u[32];
    end
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r  = s[31:0];
`ifdef ADDER_PIPE_SAT_EN
    if (ov) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {r, co, ov};
  endfunction

  // Compare process: away from the active edge, checks the handshake rule,
  // stability under backpressure, and every output transfer against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (hold_pending)
        check("hold_stable", {29'd0, out_valid, sum, cout, ovf}, {29'd0, 1'b1, held_vals});
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {30'd0, sum, cout, ovf}, 64'hDEAD);
        end else begin
          check("stream_result", {30'd0, sum, cout, ovf}, {30'd0, exp_q.pop_front()});
        end
      end
      hold_pending = out_valid && !out_ready;
      held_vals    = {sum, cout, ovf};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_acc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    s_in_valid   = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum",       {32'd0, sum},       64'd0);
    check("rst_cout_ovf",  {62'd0, cout, ovf}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_s_out",     {46'd0, s_out_valid, s_sum, s_cout}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Hold the current op until it is accepted; returns at posedge+1.
  task automatic wait_ready(input string nm);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check({nm, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  // One op into an empty pipe with Out_ready=1; checks latency and literals.
  task automatic run_one(input string nm, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic c_in, input logic is_sub,
                         input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
    int n;
    a = op_a; b = op_b; cin = c_in; sub = is_sub; in_valid = 1'b1;
    wait_ready(nm);
    in_valid = 1'b0;
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 64'(n), 64'(STAGES));
    check({nm, "_sum"},     {32'd0, sum},  {32'd0, e_sum});
    check({nm, "_cout"},    {63'd0, cout}, {63'd0, e_cout});
    check({nm, "_ovf"},     {63'd0, ovf},  {63'd0, e_ovf});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int out_start;
    int guard;
    int target;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;

    // Pin the model with hand-computed values.
    check("model_pin_add", {30'd0, model(32'd1, 32'd3, 1'b0, 1'b0)}, {30'd0, 32'd4, 1'b0, 1'b0});
    check("model_pin_sub", {30'd0, model(32'd5, 32'd7, 1'b0, 1'b1)}, {30'd0, 32'hFFFF_FFFE, 1'b0, 1'b0});
`ifdef ADDER_PIPE_SAT_EN
    check("model_pin_ovf", {30'd0, model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0)}, {30'd0, 32'h7FFF_FFFF, 1'b0, 1'b1});
`else
    check("model_pin_ovf", {30'd0, model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0)}, {30'd0, 32'h8000_0000, 1'b0, 1'b1});
`endif

    do_reset();

    // Directed single ops with literal expectations.
    run_one("t1_carry_all",  32'hFFFF_FFFF, 32'h0,   1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("t1_slice_edge", 32'h0000_00FF, 32'h1,   1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_one("t2_sub_neg",    32'd5,         32'd7,   1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("t2_sub_pos",    32'd7,         32'd5,   1'b1, 1'b1, 32'd2,         1'b1, 1'b0);
`ifdef ADDER_PIPE_SAT_EN
    run_one("t3_pos_ovf",    32'h7FFF_FFFF, 32'd1,   1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_one("t3_neg_ovf",    32'h8000_0000, 32'd1,   1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    run_one("t3_add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
`else
    run_one("t3_pos_ovf",    32'h7FFF_FFFF, 32'd1,   1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("t3_neg_ovf",    32'h8000_0000, 32'd1,   1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("t3_add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`endif

    // Test 4: 8 back-to-back ops, Out_ready low for three cycles mid-stream.
    out_start = n_out;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          a = 32'(i); b = 32'(i * 3); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
          wait_ready("t4_accept");
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("t4_stall_in_ready", {63'd0, in_ready}, 64'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("t4");
    check("t4_result_count", 64'(n_out - out_start), 64'd8);

    // Test 5: reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      a = 32'(100 + i); b = 32'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      wait_ready("t5_accept");
    end
    in_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_stale_out", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    run_one("t5_after_reset", 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0);

    // Test 6: single-stage instance, latency 1.
    s_a = 16'hFFFF; s_b = 16'h0001; s_in_valid = 1'b1;
    @(negedge clk);
    check("t6_s_in_ready", {63'd0, s_in_ready}, 64'd1);
    @(posedge clk); #1;
    s_a = 16'h7FFF; s_b = 16'h0001;
    @(negedge clk);
    check("t6_s_wrap", {46'd0, s_out_valid, s_sum, s_cout}, {46'd0, 1'b1, 16'h0000, 1'b1});
    check("t6_s_wrap_ovf", {63'd0, s_ovf}, 64'd0);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
`ifdef ADDER_PIPE_SAT_EN
    check("t6_s_ovf", {45'd0, s_out_valid, s_sum, s_cout, s_ovf}, {45'd0, 1'b1, 16'h7FFF, 1'b0, 1'b1});
`else
    check("t6_s_ovf", {45'd0, s_out_valid, s_sum, s_cout, s_ovf}, {45'd0, 1'b1, 16'h8000, 1'b0, 1'b1});
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_s_bubble", {63'd0, s_out_valid}, 64'd0);
    @(posedge clk); #1;

    // Random In_valid / Out_ready traffic against the model.
    target = n_acc + 2000;
    guard  = 0;
    while (n_acc < target && guard < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rand_operand();
      b         = rand_operand();
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      guard++;
    end
    check("rand_progress", {63'd0, (n_acc >= target)}, 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
